// File: rtl/issue_buffer_pkg.sv
// Shared types for the decode-side issue buffer: core configuration and unit class.
// The per-entry struct depends on XLEN and is therefore declared inside issue_buffer.
package issue_buffer_pkg;

    typedef struct packed {
        int XLEN;
        bit F_SUPPORTED;
        bit ZMMUL_SUPPORTED;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32, F_SUPPORTED: 1'b1, ZMMUL_SUPPORTED: 1'b1};

    typedef enum logic [2:0] {
        ISS_ALU = 3'd0,
        ISS_MDU = 3'd1,
        ISS_FPU = 3'd2,
        ISS_MEM = 3'd3,
        ISS_SYS = 3'd4
    } issue_class_t;

endpackage

// File: rtl/issue_fifo.sv
// Generic circular storage with head/tail/count; flush clears pointers and count.
// One enqueue and one dequeue per cycle; caller guarantees no enq when full or deq when empty.
module issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     enq_i,
    input  logic                     deq_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are power-of-two wide, so the increment wraps naturally.
            if (enq_i) tail_d = tail_q + 1'b1;
            if (deq_i) head_d = head_q + 1'b1;
            case ({enq_i, deq_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_i && !flush_i) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/issue_buffer.sv
// In-order buffer between decode dispatch and the execution lanes; head is offered to one lane.
// Enqueue-to-offer latency is one cycle; ready from decode depends only on registered occupancy.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter cvw_t P     = CVW_DEFAULT,
    parameter int   DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     FlushD,
    input  logic                     DispValidD,
    output logic                     DispReadyD,
    input  logic [31:0]              InstrD,
    input  logic [P.XLEN-1:0]        PCD,
    input  logic                     FpuOp,
    input  logic                     MduOp,
    input  logic                     AluOp,
    input  logic                     MemOp,
    output logic                     AluIssueValid,
    output logic                     MduIssueValid,
    output logic                     FpuIssueValid,
    output logic                     MemIssueValid,
    input  logic                     AluIssueReady,
    input  logic                     MduIssueReady,
    input  logic                     FpuIssueReady,
    input  logic                     MemIssueReady,
    output logic [31:0]              IssueInstr,
    output logic [P.XLEN-1:0]        IssuePC,
    output logic                     IssueSys,
    output logic [$clog2(DEPTH):0]   Count
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [P.XLEN-1:0] pc;
        issue_class_t      cls;
    } issue_entry_t;

    localparam int EW = $bits(issue_entry_t);

    issue_class_t enq_cls;
    issue_entry_t enq_entry;
    issue_entry_t head_entry;
    logic [EW-1:0] head_raw;
    logic          fifo_full;
    logic          fifo_empty;
    logic          enq_fire;
    logic          deq_fire;
    logic          head_vld;
    logic          head_rdy;

    // Memory wins over FPU over MDU over ALU when dispatch sets several bits.
    always_comb begin
        enq_cls = ISS_SYS;
        if (MemOp)      enq_cls = ISS_MEM;
        else if (FpuOp) enq_cls = ISS_FPU;
        else if (MduOp) enq_cls = ISS_MDU;
        else if (AluOp) enq_cls = ISS_ALU;
    end

    always_comb begin
        if (enq_fire) begin
            assert ($countones({MemOp, FpuOp, MduOp, AluOp}) <= 1)
            else $warning("issue_buffer: several unit-class bits set at enqueue, using priority class");
        end
    end

    assign enq_entry.instr = InstrD;
    assign enq_entry.pc    = PCD;
    assign enq_entry.cls   = enq_cls;

    assign DispReadyD = !fifo_full;
    assign enq_fire   = DispValidD && DispReadyD && !FlushD;

    issue_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (FlushD),
        .enq_i   (enq_fire),
        .deq_i   (deq_fire),
        .wdata_i (enq_entry),
        .rdata_o (head_raw),
        .count_o (Count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_entry = head_raw;
    assign head_vld   = !fifo_empty && !FlushD;

    // Valid is formed from state and flush only; ready just selects whether the offer completes.
    always_comb begin
        AluIssueValid = 1'b0;
        MduIssueValid = 1'b0;
        FpuIssueValid = 1'b0;
        MemIssueValid = 1'b0;
        IssueSys      = 1'b0;
        head_rdy      = 1'b0;
        if (head_vld) begin
            case (head_entry.cls)
                ISS_ALU: begin
                    AluIssueValid = 1'b1;
                    head_rdy      = AluIssueReady;
                end
                ISS_SYS: begin
                    AluIssueValid = 1'b1;
                    IssueSys      = 1'b1;
                    head_rdy      = AluIssueReady;
                end
                ISS_MDU: begin
                    MduIssueValid = 1'b1;
                    head_rdy      = MduIssueReady;
                end
                ISS_FPU: begin
                    FpuIssueValid = 1'b1;
                    head_rdy      = FpuIssueReady;
                end
                ISS_MEM: begin
                    MemIssueValid = 1'b1;
                    head_rdy      = MemIssueReady;
                end
                default: head_rdy = 1'b0;
            endcase
        end
    end

    assign deq_fire   = head_vld && head_rdy;
    assign IssueInstr = head_entry.instr;
    assign IssuePC    = head_entry.pc;

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: handshake, blocking, full/wrap, system ops, flush and async reset.
module tb_issue_buffer;

    logic        clk;
    logic        reset_n;
    logic        FlushD;
    logic        DispValidD;
    logic        DispReadyD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic        FpuOp, MduOp, AluOp, MemOp;
    logic        AluIssueValid, MduIssueValid, FpuIssueValid, MemIssueValid;
    logic        AluIssueReady, MduIssueReady, FpuIssueReady, MemIssueReady;
    logic [31:0] IssueInstr;
    logic [31:0] IssuePC;
    logic        IssueSys;
    logic [2:0]  Count;

    int n_pass  = 0;
    int n_total = 0;

    issue_buffer #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .FlushD        (FlushD),
        .DispValidD    (DispValidD),
        .DispReadyD    (DispReadyD),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .FpuOp         (FpuOp),
        .MduOp         (MduOp),
        .AluOp         (AluOp),
        .MemOp         (MemOp),
        .AluIssueValid (AluIssueValid),
        .MduIssueValid (MduIssueValid),
        .FpuIssueValid (FpuIssueValid),
        .MemIssueValid (MemIssueValid),
        .AluIssueReady (AluIssueReady),
        .MduIssueReady (MduIssueReady),
        .FpuIssueReady (FpuIssueReady),
        .MemIssueReady (MemIssueReady),
        .IssueInstr    (IssueInstr),
        .IssuePC       (IssuePC),
        .IssueSys      (IssueSys),
        .Count         (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_instr;
        reset_n = 1'b0;
        FlushD = 1'b0; DispValidD = 1'b0; InstrD = '0; PCD = '0;
        FpuOp = 1'b0; MduOp = 1'b0; AluOp = 1'b0; MemOp = 1'b0;
        AluIssueReady = 1'b0; MduIssueReady = 1'b0; FpuIssueReady = 1'b0; MemIssueReady = 1'b0;
        step();
        step();
        chk("rst_count", Count, 0);
        chk("rst_ready", DispReadyD, 1);
        chk("rst_valids", {AluIssueValid, MduIssueValid, FpuIssueValid, MemIssueValid}, 0);
        chk("rst_sys", IssueSys, 0);
        reset_n = 1'b1;

        // Single ALU op: offered one cycle after enqueue, never bypassed.
        DispValidD = 1'b1; InstrD = 32'h00B5_0533; PCD = 32'h8000_0000; AluOp = 1'b1;
        AluIssueReady = 1'b1;
        #1;
        chk("add_no_bypass", AluIssueValid, 0);
        step();
        DispValidD = 1'b0; AluOp = 1'b0;
        #1;
        chk("add_count", Count, 1);
        chk("add_valid", AluIssueValid, 1);
        chk("add_sys", IssueSys, 0);
        chk("add_instr", IssueInstr, 32'h00B5_0533);
        chk("add_pc", IssuePC, 32'h8000_0000);
        step();
        chk("add_drained", Count, 0);
        chk("add_valid_off", AluIssueValid, 0);
        AluIssueReady = 1'b0;

        // mul then ld; a stalled MDU lane blocks the ld behind it.
        DispValidD = 1'b1; InstrD = 32'h02B5_0533; PCD = 32'h8000_0004; MduOp = 1'b1;
        step();
        InstrD = 32'h0005_B503; PCD = 32'h8000_0008; MduOp = 1'b0; MemOp = 1'b1;
        step();
        DispValidD = 1'b0; MemOp = 1'b0; MemIssueReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mul_held", MduIssueValid, 1);
            chk("ld_blocked", MemIssueValid, 0);
            chk("mul_instr", IssueInstr, 32'h02B5_0533);
            step();
        end
        chk("mul_count", Count, 2);
        MduIssueReady = 1'b1;
        step();
        chk("ld_offered", MemIssueValid, 1);
        chk("mul_gone", MduIssueValid, 0);
        chk("ld_instr", IssueInstr, 32'h0005_B503);
        chk("ld_pc", IssuePC, 32'h8000_0008);
        step();
        chk("ld_drained", Count, 0);
        MduIssueReady = 1'b0; MemIssueReady = 1'b0;

        // Fill to DEPTH with the pointers starting at 3 so they wrap.
        DispValidD = 1'b1; AluOp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            InstrD = 32'h1000_0000 + i;
            step();
        end
        InstrD = 32'h1000_0004;
        AluIssueReady = 1'b1;
        #1;
        chk("full_count", Count, 4);
        chk("full_notready", DispReadyD, 0);
        chk("full_head", IssueInstr, 32'h1000_0000);
        step();
        chk("full_deq_count", Count, 3);
        chk("full_ready_back", DispReadyD, 1);
        for (int j = 0; j < 10; j++) begin
            InstrD = 32'h2000_0000 + j;
            exp_instr = (j < 3) ? 32'h1000_0001 + j : 32'h2000_0000 + (j - 3);
            #1;
            chk("wrap_order", IssueInstr, exp_instr);
            step();
            chk("wrap_count", Count, 3);
        end
        DispValidD = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drain_order", IssueInstr, 32'h2000_0007 + k);
            step();
        end
        chk("drain_count", Count, 0);
        AluIssueReady = 1'b0; AluOp = 1'b0;

        // ecall: no class bits, offered on the ALU lane as a system op.
        DispValidD = 1'b1; InstrD = 32'h0000_0073;
        step();
        DispValidD = 1'b0;
        #1;
        chk("ecall_alu", AluIssueValid, 1);
        chk("ecall_sys", IssueSys, 1);
        chk("ecall_others", {MduIssueValid, FpuIssueValid, MemIssueValid}, 0);
        AluIssueReady = 1'b1;
        step();
        chk("ecall_drained", Count, 0);
        chk("ecall_sys_off", IssueSys, 0);
        AluIssueReady = 1'b0;

        // Flush with three MEM entries and a concurrent dispatch.
        DispValidD = 1'b1; MemOp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            InstrD = 32'h3000_0000 + i;
            step();
        end
        FlushD = 1'b1; InstrD = 32'h3FFF_FFFF; MemIssueReady = 1'b1;
        #1;
        chk("flush_count_pre", Count, 3);
        chk("flush_no_valid", MemIssueValid, 0);
        step();
        chk("flush_count", Count, 0);
        chk("flush_no_offer", MemIssueValid, 0);
        FlushD = 1'b0; MemIssueReady = 1'b0; MemOp = 1'b0; AluOp = 1'b1;
        InstrD = 32'h4000_0000;
        step();
        InstrD = 32'h4000_0001;
        step();
        DispValidD = 1'b0; AluOp = 1'b0;
        #1;
        chk("postflush_count", Count, 2);
        chk("postflush_head", IssueInstr, 32'h4000_0000);
        AluIssueReady = 1'b1;
        step();
        chk("postflush_second", IssueInstr, 32'h4000_0001);
        step();
        chk("postflush_drained", Count, 0);
        AluIssueReady = 1'b0;

        // MEM+FPU both set: classed MEM. Then async reset between edges.
        DispValidD = 1'b1; MemOp = 1'b1; FpuOp = 1'b1; InstrD = 32'h5000_0000;
        step();
        FpuOp = 1'b0; InstrD = 32'h5000_0001;
        step();
        DispValidD = 1'b0; MemOp = 1'b0;
        #1;
        chk("multi_count", Count, 2);
        chk("multi_mem", MemIssueValid, 1);
        chk("multi_not_fpu", FpuIssueValid, 0);
        chk("multi_instr", IssueInstr, 32'h5000_0000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", Count, 0);
        chk("arst_valid", MemIssueValid, 0);
        chk("arst_ready", DispReadyD, 1);
        step();
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
- In-order instruction buffer directly downstream of the Decode-stage dispatch classifier.
- Captures each decoded instruction with its PC and one-hot unit class (ALU/MDU/FPU/MEM, or none = system).
- Holds up to DEPTH entries and issues the head entry to exactly one execution lane over a valid/ready handshake.
- Decouples decode from back-pressure in the execution units.

Parameters:
- P, cvw_t, core configuration; provides XLEN, F_SUPPORTED, ZMMUL_SUPPORTED.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous, active-low reset.
- FlushD  input  1  synchronous flush; discards all buffered entries.
- DispValidD  input  1  decode presents a valid instruction.
- DispReadyD  output  1  buffer can accept an instruction this cycle.
- InstrD  input  32  instruction word.
- PCD  input  P.XLEN  instruction PC.
- FpuOp, MduOp, AluOp, MemOp  input  1 each  unit class from dispatch; all zero means system/privileged.
- AluIssueValid, MduIssueValid, FpuIssueValid, MemIssueValid  output  1 each  head entry is offered to that lane.
- AluIssueReady, MduIssueReady, FpuIssueReady, MemIssueReady  input  1 each  lane accepts the offer.
- IssueInstr  output  32  head instruction, shared by all lanes.
- IssuePC  output  P.XLEN  head PC.
- IssueSys  output  1  head is a system op; it is offered on the ALU lane.
- Count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous): head=0, tail=0, Count=0, all IssueValid=0, IssueSys=0, DispReadyD=1. IssueInstr and IssuePC are don't-care while no IssueValid is high.
- Class encoding at enqueue:
  - MemOp > FpuOp > MduOp > AluOp priority when more than one bit is set.
  - More than one bit set also fires a simulation assertion (illegal).
  - No bit set → class SYS.
- DispReadyD = (Count != DEPTH). It is a function of registered state only; there is no full-bypass.
- Enqueue fires when DispValidD & DispReadyD & !FlushD. The entry is written at tail; tail increments modulo DEPTH.
- Head offer: when Count != 0 and !FlushD, exactly one lane valid is asserted, chosen by the head class. SYS asserts AluIssueValid together with IssueSys=1.
- Dequeue fires when the selected lane's valid and ready are both high; head increments modulo DEPTH.
- Non-selected ready inputs are ignored.
- Latency: an instruction enqueued at edge N is offered at the head no earlier than cycle N+1 (no bypass from DispValidD).
- Throughput: 1 enqueue and 1 dequeue per cycle.
- Count update: simultaneous enqueue and dequeue → Count unchanged; enqueue only → +1; dequeue only → −1.
- Full: DispReadyD=0. A dequeue in the same cycle does not allow an enqueue that cycle; DispReadyD rises the following cycle.
- Empty: all IssueValid=0. An enqueue into an empty buffer is offered the next cycle.
- Pointer wrap: head and tail wrap from DEPTH−1 to 0. Full vs empty is distinguished by Count, not by pointer equality.
- FlushD (priority over everything):
  - Forces all IssueValid=0 that cycle, so no dequeue occurs.
  - Blocks enqueue that cycle.
  - At the next edge: head=tail=0, Count=0.
- Reset mid-operation: all entries are discarded immediately; state is identical to the post-reset state.
- Stability: once an IssueValid is asserted it stays high, with stable IssueInstr/IssuePC/IssueSys, until handshake or FlushD.
- Lane readiness: the lane does not depend on valid to raise ready. The buffer never depends on ready combinationally to form valid.

Decomposition:
- cvw package holds:
  - issue_class_t enum {ISS_ALU, ISS_MDU, ISS_FPU, ISS_MEM, ISS_SYS}.
  - issue_entry_t struct {logic [31:0] instr; logic [XLEN-1:0] pc; issue_class_t cls}. Since it is XLEN-dependent, define it inside the module using P.XLEN.
- One sub-module: issue_fifo. It is generic storage with head/tail/count, parameterized by width and DEPTH, and has enq/deq/flush inputs. Class encoding and lane-offer logic stay in issue_buffer.

Test Plan:
- Reset, then enqueue add (0x00B50533, AluOp=1, PC=0x80000000) → next cycle AluIssueValid=1, IssueSys=0, IssueInstr=0x00B50533; with AluIssueReady=1, Count returns to 0.
- Enqueue mul (MduOp) then ld (MemOp) with MduIssueReady=0 for 3 cycles → MduIssueValid held high, MemIssueValid=0 (in-order blocking); after ready, the ld is offered the following cycle.
- Fill 4 entries with all lanes not ready → Count=4, DispReadyD=0; a cycle with dequeue plus DispValidD → no enqueue that cycle, Count=3, DispReadyD=1 next cycle; 10 further enq/deq cycles verify pointer wrap and FIFO order.
- Enqueue ecall (0x00000073, all class bits 0) → AluIssueValid=1 with IssueSys=1.
- Count=3 with FlushD and DispValidD both high → no IssueValid that cycle, no enqueue, Count=0 next cycle; the next enqueue is offered in order.
- Assert reset_n=0 asynchronously mid-cycle with Count=2 → Count=0 and all IssueValid=0 immediately, without waiting for a clock edge; MemOp and FpuOp both set fires the assertion, and the entry is classed MEM.
